push_race_counter: RTL and testbench
====================================

Name: push_race_counter

Overview:
Parametrised N-player button-mash round counter for the game datapath; successor to the fixed two-player speed-round counter. Synchronises and edge-detects each raw pushbutton, counts presses per player during a self-timed round, then sequentially compares the counts. Reports winner index, tie flag and winning count to the game FSM with a one-cycle done pulse.

Parameters:
NUM_PLAYERS, 2, number of button channels (2..16)
CNT_W, 8, per-player press counter width; counters saturate
ROUND_CYCLES, 1000, round length in clk cycles (>=1)
IDX_W, 4, width of winner index (must satisfy 2^IDX_W >= NUM_PLAYERS)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous active-high reset
pb  in  NUM_PLAYERS  raw asynchronous pushbuttons, bit i = player i
start  in  1  begin round; honoured only in IDLE
abort  in  1  cancel round; honoured in RUN and CMP
busy  out  1  high in RUN, CMP and DONE
done  out  1  one-cycle pulse when results become valid
winner  out  IDX_W  index of highest count (lowest index among equals)
tie  out  1  two or more players share the highest count
best_count  out  CNT_W  highest count
counts  out  NUM_PLAYERS*CNT_W  live counters, player i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (synchronous, rst high at clk edge): state IDLE; all counters, winner, tie, best_count, done, busy = 0; sync/edge flops = 0. Reset mid-round discards the round with no done pulse.
- Per channel: 2-flop synchroniser, then a rising-edge detector giving a 1-cycle press pulse. Runs in every state. A button held across start is not counted; only a 0->1 transition seen inside RUN counts.
- FSM states: IDLE, RUN, CMP, DONE.
- IDLE: start=1 -> RUN. On the same edge: clear all counters and load the timer with ROUND_CYCLES-1. Results from the previous round hold until this edge, then clear to 0.
- RUN: each press pulse increments that player's counter, saturating at 2^CNT_W-1. Simultaneous presses by different players all count in the same cycle. The timer decrements each cycle. timer==0 is the last counted cycle -> CMP with idx=0. RUN therefore lasts exactly ROUND_CYCLES cycles.
- CMP: one player per cycle, idx 0..NUM_PLAYERS-1. Presses are ignored.
  - idx 0: best=cnt[0], win=0, tie=0.
  - cnt[idx] > best: best=cnt[idx], win=idx, tie=0.
  - cnt[idx] == best: tie=1, win unchanged.
  - cnt[idx] < best: no change.
  - After idx=NUM_PLAYERS-1 -> DONE.
- DONE: one cycle. done=1; winner/tie/best_count hold the final values and stay stable until the next start is accepted. Next state IDLE.
- Latency: start sampled at edge t -> done high during cycle t+ROUND_CYCLES+NUM_PLAYERS+1.
- abort in RUN or CMP -> IDLE. Counters are cleared, results stay 0, no done pulse. abort has priority over timer expiry in the same cycle. abort in IDLE or DONE is ignored.
- start while not in IDLE is ignored. If start and abort are both high in IDLE, start wins.
- All zero counts: winner=0, tie=1 if NUM_PLAYERS>1, best_count=0.
- counts always reflects the live counters. They are frozen from CMP onwards until the next start.

Decomposition:
- Shared game package:
  - state encoding (IDLE=0, RUN=1, CMP=2, DONE=3)
  - timer-width helper: clog2 of ROUND_CYCLES
  - default ROUND_CYCLES constant
- Sub-module push_edge_sync: one instance per channel via generate. Contains the 2-flop synchroniser and rising-edge pulse, using the same clk/rst.
- Counters, timer, comparator and FSM live in the top level.

Test Plan:
- NUM_PLAYERS=4, ROUND_CYCLES=100: players 0..3 press 3,7,5,2 times inside the round -> done exactly 105 cycles after start is sampled; winner=1, tie=0, best_count=7, counts={2,5,7,3}.
- Same config, presses 6,6,4,6 -> winner=0, tie=1, best_count=6. Then players 3,1 press 9,8 -> winner=3, tie=0, best_count=9.
- CNT_W=4: player 2 presses 20 times -> counter stops at 15, best_count=15, winner=2. Presses one cycle after RUN ends are not counted.
- Hold pb[0] high across start and release at cycle 50 -> count 0. Four simultaneous edges on all players -> all counts 1, tie=1.
- abort at cycle 40 of RUN -> no done, busy=0 next cycle, counts=0. A start issued during RUN is ignored: the round length stays 100.
- rst asserted mid-CMP -> next cycle all outputs 0, state IDLE. A fresh start after reset gives correct results.

Source files
------------

// File: rtl/push_race_counter_pkg.sv
// rtl/push_race_counter_pkg.sv - shared state encoding and sizing helpers for the push race counter
package push_race_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_ROUND_CYCLES = 1000;

  // The timer counts ROUND_CYCLES-1 down to 0; a one-cycle round still needs one bit.
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/push_edge_sync.sv
// rtl/push_edge_sync.sv - two-flop synchroniser plus rising-edge press pulse for one button
module push_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic press
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pb_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign press = sync_q & ~prev_q;

endmodule

// File: rtl/push_race_counter.sv
// rtl/push_race_counter.sv - N-player timed press counter with sequential winner search
module push_race_counter
  import push_race_counter_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int CNT_W        = 8,
  parameter int ROUND_CYCLES = DEFAULT_ROUND_CYCLES,
  parameter int IDX_W        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       pb,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             winner,
  output logic                         tie,
  output logic [CNT_W-1:0]             best_count,
  output logic [NUM_PLAYERS*CNT_W-1:0] counts
);

  localparam int               TW         = timer_w(ROUND_CYCLES);
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PLAYERS - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] cnt_q [NUM_PLAYERS];
  logic [CNT_W-1:0] cnt_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] press;
  logic [CNT_W-1:0] cur_cnt;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
    push_edge_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .pb_raw (pb[i]),
      .press  (press[i])
    );
    assign counts[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (idx_q == IDX_W'(i)) cur_cnt = cnt_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    best_d   = best_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          timer_d  = TIMER_LOAD;
          winner_d = '0;
          tie_d    = 1'b0;
          best_d   = '0;
          for (int i = 0; i < NUM_PLAYERS; i++) cnt_d[i] = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (press[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        timer_d = timer_q - TW'(1);
        if (timer_q == '0) begin
          state_d = ST_CMP;
          idx_d   = '0;
        end
      end
      ST_CMP: begin
        if (idx_q == '0) begin
          best_d   = cur_cnt;
          winner_d = '0;
          tie_d    = 1'b0;
        end else if (cur_cnt > best_q) begin
          best_d   = cur_cnt;
          winner_d = idx_q;
          tie_d    = 1'b0;
        end else if (cur_cnt == best_q) begin
          tie_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides both timer expiry and the comparison walk.
    if (abort && (state_q == ST_RUN || state_q == ST_CMP)) begin
      state_d  = ST_IDLE;
      winner_d = '0;
      tie_d    = 1'b0;
      best_d   = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      best_q   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      best_q   <= best_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign winner     = winner_q;
  assign tie        = tie_q;
  assign best_count = best_q;

endmodule

// File: tb/tb_push_race_counter.sv
// tb/tb_push_race_counter.sv - scoreboard bench for push_race_counter with a press-counting model
module tb_push_race_counter;

  localparam int N       = 4;
  localparam int CW      = 4;
  localparam int R       = 100;
  localparam int IW      = 2;
  localparam int PAT_LEN = R + N + 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    pb;
  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic [IW-1:0]   winner;
  logic            tie;
  logic [CW-1:0]   best_count;
  logic [N*CW-1:0] counts;

  push_race_counter #(
    .NUM_PLAYERS  (N),
    .CNT_W        (CW),
    .ROUND_CYCLES (R),
    .IDX_W        (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pb         (pb),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .tie        (tie),
    .best_count (best_count),
    .counts     (counts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0]   winner;
    logic            tie;
    logic [CW-1:0]   best;
    logic [N*CW-1:0] counts;
    int              done_cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] pat [PAT_LEN];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // A level driven at the negedge after edge e0+c shows up as a press two edges
  // later, so only rises at c <= R-3 land inside the R-cycle counting window.
  function automatic exp_t model(input logic [N-1:0] pre);
    exp_t         e;
    int           cnt [N];
    logic [N-1:0] prev;
    int           best;
    int           nbest;
    prev = pre;
    for (int p = 0; p < N; p++) cnt[p] = 0;
    for (int c = 0; c < PAT_LEN; c++) begin
      for (int p = 0; p < N; p++) begin
        if (pat[c][p] && !prev[p] && c <= R - 3 && cnt[p] < (1 << CW) - 1) cnt[p]++;
      end
      prev = pat[c];
    end
    best = 0;
    for (int p = 0; p < N; p++) if (cnt[p] > best) best = cnt[p];
    nbest    = 0;
    e.winner = '0;
    for (int p = N - 1; p >= 0; p--) begin
      if (cnt[p] == best) begin
        nbest++;
        e.winner = IW'(p);
      end
    end
    e.tie  = (nbest > 1);
    e.best = CW'(best);
    for (int p = 0; p < N; p++) e.counts[p*CW +: CW] = CW'(cnt[p]);
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic clear_pat();
    for (int c = 0; c < PAT_LEN; c++) pat[c] = '0;
  endtask

  task automatic add_presses(input int p, input int n, input int first);
    for (int i = 0; i < n; i++) pat[first + 2*i][p] = 1'b1;
  endtask

  // mode 0: normal round, 1: abort in RUN, 2: reset during CMP
  task automatic run_round(input logic [N-1:0] pre, input int mode, input bit extra_start);
    exp_t e;
    int   e0;
    @(negedge clk);
    pb = pre;
    repeat (4) @(negedge clk);
    e = model(pre);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    e.done_cyc = e0 + R + N;
    if (mode == 0) sb_q.push_back(e);
    check("busy_after_start", 64'(busy), 64'd1);
    check("results_cleared_at_start", 64'({winner, tie, best_count}), 64'd0);
    for (int c = 0; c < PAT_LEN; c++) begin
      pb = pat[c];
      if (extra_start) start = (c == 30);
      if (mode == 1) begin
        if (c == 41) begin
          check("abort_busy", 64'(busy), 64'd0);
          check("abort_counts", 64'(counts), 64'd0);
          check("abort_results", 64'({winner, tie, best_count}), 64'd0);
        end
        abort = (c == 40);
      end
      if (mode == 2) begin
        if (c == R + 2) begin
          check("rst_busy_done", 64'({busy, done}), 64'd0);
          check("rst_counts", 64'(counts), 64'd0);
          check("rst_results", 64'({winner, tie, best_count}), 64'd0);
        end
        rst = (c == R + 1);
      end
      @(negedge clk);
    end
    pb    = '0;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("winner", 64'(winner), 64'(e.winner));
        check("tie", 64'(tie), 64'(e.tie));
        check("best_count", 64'(best_count), 64'(e.best));
        check("counts", 64'(counts), 64'(e.counts));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pb    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy_done", 64'({busy, done}), 64'd0);
    check("reset_results", 64'({winner, tie, best_count}), 64'd0);
    check("reset_counts", 64'(counts), 64'd0);
    rst = 1'b0;

    clear_pat();
    add_presses(0, 3, 10); add_presses(1, 7, 11); add_presses(2, 5, 12); add_presses(3, 2, 13);
    run_round('0, 0, 1'b0);

    clear_pat();
    add_presses(0, 6, 10); add_presses(1, 6, 10); add_presses(2, 4, 30); add_presses(3, 6, 50);
    run_round('0, 0, 1'b0);

    clear_pat();
    add_presses(3, 9, 8); add_presses(1, 8, 40);
    run_round('0, 0, 1'b0);

    clear_pat();
    add_presses(2, 20, 5);
    pat[R-3][0] = 1'b1;
    pat[R-2][1] = 1'b1;
    run_round('0, 0, 1'b0);

    clear_pat();
    for (int c = 0; c < 50; c++) pat[c][0] = 1'b1;
    add_presses(2, 2, 60);
    run_round(4'b0001, 0, 1'b0);

    clear_pat();
    pat[20] = '1;
    run_round('0, 0, 1'b0);

    clear_pat();
    add_presses(1, 4, 10);
    run_round('0, 1, 1'b0);

    clear_pat();
    add_presses(0, 3, 20); add_presses(2, 5, 40);
    run_round('0, 0, 1'b1);

    clear_pat();
    add_presses(1, 5, 10);
    run_round('0, 2, 1'b0);

    clear_pat();
    add_presses(0, 3, 10); add_presses(1, 7, 11); add_presses(2, 5, 12); add_presses(3, 2, 13);
    run_round('0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic [N-1:0] pre;
      for (int c = 0; c < PAT_LEN; c++) begin
        for (int p = 0; p < N; p++) pat[c][p] = ($urandom_range(0, 15) == 0);
      end
      pre = N'($urandom_range(0, (1 << N) - 1));
      run_round(pre, 0, 1'b0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
